// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-master APB arbiter.
// The response record is sized for the 32-bit APB data path used on this bus.
package apb_arb_pkg;

  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_S0   = 2'b01;
  localparam logic [1:0] GNT_S1   = 2'b10;

  typedef struct packed {
    logic [APB_DATA_W-1:0] prdata;
    logic                  pslverr;
  } resp_t;

endpackage

// File: rtl/apb_arb_rr2.sv
// Combinational two-requester round-robin picker.
// last_gnt = 1 means port 1 owned the previous transfer, so port 0 wins a tie.
module apb_arb_rr2
  import apb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = GNT_NONE;
    unique case (req)
      2'b01:   gnt = GNT_S0;
      2'b10:   gnt = GNT_S1;
      2'b11:   gnt = last_gnt ? GNT_S0 : GNT_S1;
      default: gnt = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/apb_mst_arbiter.sv
// Two-master to one-slave APB arbiter: the winning request is latched, replayed
// downstream as SETUP/ACCESS, and the response is returned to its owner.
module apb_mst_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  pclk,
  input  logic                  prst_n,
  input  logic                  s0_psel,
  input  logic                  s0_penable,
  input  logic                  s0_pwrite,
  input  logic [ADDR_WIDTH-1:0] s0_paddr,
  input  logic [DATA_WIDTH-1:0] s0_pwdata,
  output logic [DATA_WIDTH-1:0] s0_prdata,
  output logic                  s0_pready,
  output logic                  s0_pslverr,
  input  logic                  s1_psel,
  input  logic                  s1_penable,
  input  logic                  s1_pwrite,
  input  logic [ADDR_WIDTH-1:0] s1_paddr,
  input  logic [DATA_WIDTH-1:0] s1_pwdata,
  output logic [DATA_WIDTH-1:0] s1_prdata,
  output logic                  s1_pready,
  output logic                  s1_pslverr,
  output logic                  m_psel,
  output logic                  m_penable,
  output logic                  m_pwrite,
  output logic [ADDR_WIDTH-1:0] m_paddr,
  output logic [DATA_WIDTH-1:0] m_pwdata,
  input  logic [DATA_WIDTH-1:0] m_prdata,
  input  logic                  m_pready,
  input  logic                  m_pslverr,
  output logic [1:0]            arb_gnt,
  output logic                  arb_timeout
);

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e                state_reg, state_next;
  logic [1:0]            gnt_reg, gnt_next;
  logic                  last_gnt_reg, last_gnt_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic                  write_reg, write_next;
  resp_t                 resp_reg, resp_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  timeout_reg, timeout_next;
  logic [1:0]            pick;

  apb_arb_rr2 u_rr2 (
    .req      ({s1_psel, s0_psel}),
    .last_gnt (last_gnt_reg),
    .gnt      (pick)
  );

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_reg    <= IDLE;
      gnt_reg      <= GNT_NONE;
      last_gnt_reg <= 1'b1;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      write_reg    <= 1'b0;
      resp_reg     <= '0;
      cnt_reg      <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      last_gnt_reg <= last_gnt_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      write_reg    <= write_next;
      resp_reg     <= resp_next;
      cnt_reg      <= cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    last_gnt_next = last_gnt_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    write_next    = write_reg;
    resp_next     = resp_reg;
    cnt_next      = cnt_reg;
    timeout_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick != GNT_NONE) begin
          gnt_next   = pick;
          addr_next  = pick[1] ? s1_paddr  : s0_paddr;
          wdata_next = pick[1] ? s1_pwdata : s0_pwdata;
          write_next = pick[1] ? s1_pwrite : s0_pwrite;
          resp_next  = '0;
          cnt_next   = '0;
          state_next = SETUP;
        end
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        if (m_pready) begin
          resp_next.prdata  = write_reg ? '0 : m_prdata;
          resp_next.pslverr = m_pslverr;
          state_next        = RESP;
        end else if (TO_EN && (cnt_reg == CNT_LAST)) begin
          // Abort a hung slave: the owner gets an error instead of waiting forever.
          resp_next.prdata  = '0;
          resp_next.pslverr = 1'b1;
          timeout_next      = 1'b1;
          state_next        = RESP;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RESP: begin
        last_gnt_next = gnt_reg[1];
        gnt_next      = GNT_NONE;
        cnt_next      = '0;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  logic busy, s0_resp, s1_resp;

  // A master that has dropped psel/penable before its response is not answered.
  assign busy    = (state_reg == SETUP) || (state_reg == ACCESS);
  assign s0_resp = (state_reg == RESP) && gnt_reg[0] && s0_psel && s0_penable;
  assign s1_resp = (state_reg == RESP) && gnt_reg[1] && s1_psel && s1_penable;

  assign m_psel     = busy;
  assign m_penable  = (state_reg == ACCESS);
  assign m_pwrite   = busy ? write_reg : 1'b0;
  assign m_paddr    = busy ? addr_reg  : '0;
  assign m_pwdata   = busy ? wdata_reg : '0;

  assign s0_pready  = s0_resp;
  assign s0_prdata  = s0_resp ? resp_reg.prdata  : '0;
  assign s0_pslverr = s0_resp ? resp_reg.pslverr : 1'b0;
  assign s1_pready  = s1_resp;
  assign s1_prdata  = s1_resp ? resp_reg.prdata  : '0;
  assign s1_pslverr = s1_resp ? resp_reg.pslverr : 1'b0;

  assign arb_gnt     = gnt_reg;
  assign arb_timeout = timeout_reg;

endmodule

// File: tb/tb_apb_mst_arbiter.sv
// Directed self-checking bench for apb_mst_arbiter with a small behavioural APB slave.
module tb_apb_mst_arbiter;

  logic        pclk = 1'b0;
  logic        prst_n;
  logic        s0_psel, s0_penable, s0_pwrite;
  logic [31:0] s0_paddr, s0_pwdata, s0_prdata;
  logic        s0_pready, s0_pslverr;
  logic        s1_psel, s1_penable, s1_pwrite;
  logic [31:0] s1_paddr, s1_pwdata, s1_prdata;
  logic        s1_pready, s1_pslverr;
  logic        m_psel, m_penable, m_pwrite;
  logic [31:0] m_paddr, m_pwdata, m_prdata;
  logic        m_pready, m_pslverr;
  logic [1:0]  arb_gnt;
  logic        arb_timeout;
  logic [137:0] all_out;

  int n_cmp = 0;
  int n_bad = 0;

  int          slave_wait  = 0;
  bit          slave_hang  = 0;
  logic [31:0] slave_rdata = '0;
  logic        slave_err   = 1'b0;
  int          acc_cnt     = 0;

  apb_mst_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .pclk(pclk), .prst_n(prst_n),
    .s0_psel(s0_psel), .s0_penable(s0_penable), .s0_pwrite(s0_pwrite),
    .s0_paddr(s0_paddr), .s0_pwdata(s0_pwdata), .s0_prdata(s0_prdata),
    .s0_pready(s0_pready), .s0_pslverr(s0_pslverr),
    .s1_psel(s1_psel), .s1_penable(s1_penable), .s1_pwrite(s1_pwrite),
    .s1_paddr(s1_paddr), .s1_pwdata(s1_pwdata), .s1_prdata(s1_prdata),
    .s1_pready(s1_pready), .s1_pslverr(s1_pslverr),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
    .m_pready(m_pready), .m_pslverr(m_pslverr),
    .arb_gnt(arb_gnt), .arb_timeout(arb_timeout)
  );

  assign all_out = {m_psel, m_penable, m_pwrite, m_paddr, m_pwdata,
                    s0_pready, s0_pslverr, s0_prdata,
                    s1_pready, s1_pslverr, s1_prdata, arb_gnt, arb_timeout};

  always #5 pclk = ~pclk;

  // Slave: answers on the (slave_wait+1)-th ACCESS cycle unless hung.
  initial begin
    m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0;
    forever begin
      @(posedge pclk); #1;
      if (m_psel && m_penable) begin
        if (!slave_hang && acc_cnt == slave_wait) begin
          m_pready = 1'b1; m_prdata = slave_rdata; m_pslverr = slave_err;
        end else begin
          m_pready = 1'b0; m_prdata = slave_hang ? slave_rdata : '0; m_pslverr = 1'b0;
        end
        acc_cnt++;
      end else begin
        m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0; acc_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge pclk); #2;
  endtask

  task automatic idle_inputs();
    s0_psel = 0; s0_penable = 0; s0_pwrite = 0; s0_paddr = '0; s0_pwdata = '0;
    s1_psel = 0; s1_penable = 0; s1_pwrite = 0; s1_paddr = '0; s1_pwdata = '0;
    slave_wait = 0; slave_hang = 0; slave_err = 1'b0; slave_rdata = '0;
  endtask

  task automatic apply_reset();
    prst_n = 1'b0; idle_inputs(); tick(); tick();
    prst_n = 1'b1; tick();
  endtask

  task automatic test_reset();
    prst_n = 1'b0; idle_inputs(); tick(); tick();
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    prst_n = 1'b1; tick();
    n_cmp++;
    if ({m_psel, arb_gnt} !== 3'b000) begin
      n_bad++; $display("FAIL reset_idle: psel/gnt got %b want 000", {m_psel, arb_gnt});
    end
    $display("txn reset done");
  endtask

  task automatic test_write_zero_wait();
    s0_psel = 1; s0_pwrite = 1; s0_paddr = 32'h1000_0000; s0_pwdata = 32'hDEAD_BEEF;
    tick();
    n_cmp++;
    if ({m_psel, m_penable, m_pwrite, arb_gnt, m_paddr, m_pwdata} !== {3'b101, 2'b01, 32'h1000_0000, 32'hDEAD_BEEF}) begin
      n_bad++; $display("FAIL wr_setup: got psel/en/wr=%b gnt=%b addr=%h data=%h want 101 01 10000000 deadbeef",
                        {m_psel, m_penable, m_pwrite}, arb_gnt, m_paddr, m_pwdata);
    end
    s0_penable = 1; tick();
    n_cmp++;
    if ({m_psel, m_penable, s0_pready, m_pwdata} !== {3'b110, 32'hDEAD_BEEF}) begin
      n_bad++; $display("FAIL wr_access: got psel/en/rdy=%b data=%h want 110 deadbeef",
                        {m_psel, m_penable, s0_pready}, m_pwdata);
    end
    tick();
    n_cmp++;
    if ({s0_pready, s0_pslverr, s0_prdata, arb_gnt, m_psel} !== {2'b10, 32'h0, 2'b01, 1'b0}) begin
      n_bad++; $display("FAIL wr_resp: got rdy/err=%b rdata=%h gnt=%b mpsel=%b want 10 0 01 0",
                        {s0_pready, s0_pslverr}, s0_prdata, arb_gnt, m_psel);
    end
    s0_psel = 0; s0_penable = 0; tick();
    n_cmp++;
    if ({s0_pready, arb_gnt} !== 3'b000) begin
      n_bad++; $display("FAIL wr_idle: got rdy/gnt=%b want 000", {s0_pready, arb_gnt});
    end
    $display("txn s0 write addr=10000000 data=deadbeef");
  endtask

  task automatic test_read_wait();
    int n;
    slave_wait = 5; slave_rdata = 32'h1234_5678;
    s1_psel = 1; s1_pwrite = 0; s1_paddr = 32'h1000_2004;
    tick();
    n_cmp++;
    if ({arb_gnt, m_pwrite, m_paddr} !== {2'b10, 1'b0, 32'h1000_2004}) begin
      n_bad++; $display("FAIL rd_setup: got gnt=%b wr=%b addr=%h want 10 0 10002004", arb_gnt, m_pwrite, m_paddr);
    end
    s1_penable = 1; n = 0;
    do begin tick(); n++; end while (!s1_pready && n < 20);
    n_cmp++;
    if (n !== 7) begin
      n_bad++; $display("FAIL rd_latency: got %0d cycles want 7", n);
    end
    n_cmp++;
    if ({s1_pready, s1_pslverr, s1_prdata, s0_pready, s0_prdata} !== {2'b10, 32'h1234_5678, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL rd_resp: got s1 rdy/err=%b rdata=%h s0 rdy=%b rdata=%h want 10 12345678 0 0",
                        {s1_pready, s1_pslverr}, s1_prdata, s0_pready, s0_prdata);
    end
    s1_psel = 0; s1_penable = 0; tick();
    n_cmp++;
    if ({s1_pready, s1_prdata} !== 33'h0) begin
      n_bad++; $display("FAIL rd_one_cycle: got rdy=%b rdata=%h want 0 0", s1_pready, s1_prdata);
    end
    slave_wait = 0;
    $display("txn s1 read addr=10002004 data=%h", 32'h1234_5678);
  endtask

  task automatic test_back_to_back();
    int n;
    logic [1:0]  exp_gnt;
    logic [31:0] exp_addr;
    logic        rdy, other;
    apply_reset();
    s0_psel = 1; s0_pwrite = 0; s0_paddr = 32'h0000_0100;
    s1_psel = 1; s1_pwrite = 0; s1_paddr = 32'h0000_0200;
    for (int r = 0; r < 4; r++) begin
      exp_gnt  = (r % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (r % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
      slave_rdata = 32'h1111_0000 + r;
      tick();
      n_cmp++;
      if ({arb_gnt, m_psel, m_paddr} !== {exp_gnt, 1'b1, exp_addr}) begin
        n_bad++; $display("FAIL rr_grant%0d: got gnt=%b psel=%b addr=%h want %b 1 %h",
                          r, arb_gnt, m_psel, m_paddr, exp_gnt, exp_addr);
      end
      s0_penable = 1; s1_penable = 1; n = 0;
      do begin
        tick(); n++;
        rdy   = exp_gnt[0] ? s0_pready : s1_pready;
        other = exp_gnt[0] ? s1_pready : s0_pready;
      end while (!rdy && n < 10);
      n_cmp++;
      if ({rdy, other, (exp_gnt[0] ? s0_prdata : s1_prdata)} !== {2'b10, 32'h1111_0000 + r}) begin
        n_bad++; $display("FAIL rr_resp%0d: got rdy=%b other=%b want 1 0 data %h", r, rdy, other, 32'h1111_0000 + r);
      end
      if (exp_gnt[0]) s0_penable = 0; else s1_penable = 0;
      tick();
      n_cmp++;
      if ({arb_gnt, m_psel} !== 3'b000) begin
        n_bad++; $display("FAIL rr_gap%0d: got gnt/psel=%b want 000", r, {arb_gnt, m_psel});
      end
      $display("txn round %0d winner gnt=%b", r, exp_gnt);
    end
    idle_inputs(); tick();
  endtask

  task automatic test_timeout();
    int n, early;
    slave_hang = 1; slave_rdata = 32'hA5A5_A5A5;
    s0_psel = 1; s0_pwrite = 0; s0_paddr = 32'h1000_0040;
    tick(); s0_penable = 1; n = 0; early = 0;
    do begin
      tick(); n++;
      if (arb_timeout && !s0_pready) early++;
    end while (!s0_pready && n < 30);
    n_cmp++;
    if ({n, early} !== {32'd9, 32'd0}) begin
      n_bad++; $display("FAIL to_latency: got %0d cycles early_pulses=%0d want 9 0", n, early);
    end
    n_cmp++;
    if ({arb_timeout, s0_pready, s0_pslverr, s0_prdata, m_psel} !== {3'b111, 32'h0, 1'b0}) begin
      n_bad++; $display("FAIL to_resp: got to/rdy/err=%b rdata=%h mpsel=%b want 111 0 0",
                        {arb_timeout, s0_pready, s0_pslverr}, s0_prdata, m_psel);
    end
    s0_psel = 0; s0_penable = 0; slave_hang = 0; tick();
    n_cmp++;
    if ({arb_timeout, arb_gnt, m_psel} !== 4'b0000) begin
      n_bad++; $display("FAIL to_idle: got to/gnt/psel=%b want 0000", {arb_timeout, arb_gnt, m_psel});
    end
    $display("txn s0 read timeout addr=10000040");
  endtask

  task automatic test_slverr();
    int n;
    slave_err = 1'b1; slave_rdata = 32'h7777_7777;
    s1_psel = 1; s1_pwrite = 1; s1_paddr = 32'h1000_0008; s1_pwdata = 32'h0000_00FF;
    tick(); s1_penable = 1; n = 0;
    do begin tick(); n++; end while (!s1_pready && n < 10);
    n_cmp++;
    if ({s1_pready, s1_pslverr, s1_prdata} !== {2'b11, 32'h0}) begin
      n_bad++; $display("FAIL err_resp: got rdy/err=%b rdata=%h want 11 0", {s1_pready, s1_pslverr}, s1_prdata);
    end
    s1_psel = 0; s1_penable = 0; slave_err = 1'b0; slave_rdata = 32'hCAFE_F00D;
    tick();
    s0_psel = 1; s0_pwrite = 0; s0_paddr = 32'h1000_000C;
    tick(); s0_penable = 1; n = 0;
    do begin tick(); n++; end while (!s0_pready && n < 10);
    n_cmp++;
    if ({s0_pready, s0_pslverr, s0_prdata, n} !== {2'b10, 32'hCAFE_F00D, 32'd2}) begin
      n_bad++; $display("FAIL err_next: got rdy/err=%b rdata=%h cycles=%0d want 10 cafef00d 2",
                        {s0_pready, s0_pslverr}, s0_prdata, n);
    end
    s0_psel = 0; s0_penable = 0; tick();
    $display("txn s1 write slverr, s0 read cafef00d");
  endtask

  task automatic test_reset_mid();
    int n;
    slave_hang = 1; slave_rdata = 32'h5555_AAAA;
    s0_psel = 1; s0_pwrite = 1; s0_paddr = 32'h1000_0010; s0_pwdata = 32'h0BAD_CAFE;
    tick(); s0_penable = 1; tick(); tick();
    n_cmp++;
    if ({m_psel, m_penable} !== 2'b11) begin
      n_bad++; $display("FAIL rst_pre: got psel/en=%b want 11", {m_psel, m_penable});
    end
    #1 prst_n = 1'b0;
    #1;
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++; $display("FAIL rst_mid: got %h want 0", all_out);
    end
    idle_inputs(); tick(); prst_n = 1'b1; tick();
    slave_rdata = 32'h0F0F_0F0F;
    s1_psel = 1; s1_pwrite = 0; s1_paddr = 32'h1000_2000;
    tick();
    n_cmp++;
    if ({arb_gnt, m_paddr} !== {2'b10, 32'h1000_2000}) begin
      n_bad++; $display("FAIL rst_after_gnt: got gnt=%b addr=%h want 10 10002000", arb_gnt, m_paddr);
    end
    s1_penable = 1; n = 0;
    do begin tick(); n++; end while (!s1_pready && n < 10);
    n_cmp++;
    if ({s1_pready, s1_prdata} !== {1'b1, 32'h0F0F_0F0F}) begin
      n_bad++; $display("FAIL rst_after_resp: got rdy=%b rdata=%h want 1 0f0f0f0f", s1_pready, s1_prdata);
    end
    s1_psel = 0; s1_penable = 0; tick();
    $display("txn reset mid-access then s1 read 0f0f0f0f");
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_back_to_back();
    test_timeout();
    test_slverr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
